// File: rtl/nlprg_period_checker.sv
`default_nettype none
// ============================================================================
// Module      : nlprg_period_checker
// Description : Monitors an nlprg state stream, measures its period and flags
//               a maximal-length (2^N distinct states) sequence.
//               Optional repeat diagnostics: NLPRG_PERIOD_CHECKER_DIAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nlprg_period_checker #(
    parameter int N = 7
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         start,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   period,
    output logic [N-1:0] first
`ifdef NLPRG_PERIOD_CHECKER_DIAG_EN
    ,
    output logic [N-1:0] rep_val,
    output logic [N:0]   rep_idx
`endif
);

    localparam int         c_DEPTH       = 2**N;
    localparam logic [N:0] c_FULL_PERIOD = {1'b1, {N{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_RUN     = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_DEPTH-1:0] r_visited;
    logic               w_seen;

    assign w_seen = r_visited[d];
    assign busy   = (r_state == S_CAPTURE) || (r_state == S_RUN);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start)         w_next = S_CAPTURE;
            S_CAPTURE:      if (en)            w_next = S_RUN;
            S_RUN:          if (en && w_seen)  w_next = S_DONE;
            default:                           w_next = S_IDLE;
        endcase
    end

    // Datapath; en low in CAPTURE/RUN leaves every register untouched.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_visited <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            period    <= '0;
            first     <= '0;
`ifdef NLPRG_PERIOD_CHECKER_DIAG_EN
            rep_val   <= '0;
            rep_idx   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_visited <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        period    <= '0;
`ifdef NLPRG_PERIOD_CHECKER_DIAG_EN
                        rep_val   <= '0;
                        rep_idx   <= '0;
`endif
                    end
                end
                S_CAPTURE: begin
                    if (en) begin
                        first        <= d;
                        r_visited[d] <= 1'b1;
                        period       <= (N+1)'(1);
                    end
                end
                S_RUN: begin
                    if (en) begin
                        if (!w_seen) begin
                            r_visited[d] <= 1'b1;
                            period       <= period + (N+1)'(1);
                        end else begin
                            // Full period only if every state was seen and we wrapped to the start.
                            done    <= 1'b1;
                            pass    <= (d == first) && (period == c_FULL_PERIOD);
`ifdef NLPRG_PERIOD_CHECKER_DIAG_EN
                            rep_val <= d;
                            rep_idx <= period;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/nlprg_period_checker.md
Name: nlprg_period_checker

Overview:
- Downstream consumer of the nlprg pseudo-random generator output.
- Samples the generator's N-bit state stream and records which states have been visited.
- Measures the sequence period and flags whether the generator is maximal-length: all 2^N states visited exactly once before it returns to the first sampled value.
- Replaces open-loop log inspection with a synthesizable, self-checking on-chip monitor.

Parameters:
N, 7, width of generator output; bitmap depth is 2^N.

Ports:
ck      input   1     clock; all state updates on rising edge
rst     input   1     asynchronous active-high reset
start   input   1     begin a new measurement; sampled in IDLE or DONE only
en      input   1     sample-valid; d is consumed on a rising edge where en=1
d       input   N     generator output (nlprg o)
busy    output  1     measurement in progress (CAPTURE or RUN)
done    output  1     level; result valid; held until next accepted start or rst
pass    output  1     meaningful only while done=1; 1 = full period confirmed
period  output  N+1   count of distinct states seen before first repeat (0..2^N)
first   output  N     first sampled value of the current measurement

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0; done=0; pass=0; period=0; first=0; visited bitmap all 0.
- States: IDLE, CAPTURE, RUN, DONE.
- IDLE/DONE with start=1 -> CAPTURE:
  - Clear bitmap, period, pass and done in the same edge.
  - en on the start cycle is ignored.
- start while busy=1 is ignored and does not restart the measurement.
- CAPTURE, en=1 -> RUN: first<=d; bitmap[d]<=1; period<=1.
- RUN, en=1, bitmap[d]=0: bitmap[d]<=1; period<=period+1; remain in RUN.
- RUN, en=1, bitmap[d]=1 -> DONE:
  - done<=1.
  - pass<=(d==first) && (period==2^N).
  - period holds its value and is not incremented.
- en=0 in CAPTURE/RUN: full stall; no state change.
- Latency: done/pass visible the cycle after the edge that consumes the terminating sample.
- Worst case terminates on sample 2^N+1. No timeout is required because a repeat within 2^N+1 samples is guaranteed.
- period width N+1 holds 2^N exactly and never wraps.
- A period of 2^N is reachable only with all bitmap bits set.
- Early return to first (period<2^N) -> pass=0.
- Repeat of any non-first value -> pass=0 (the generator has a lock-up tail).
- All-zero stream (stuck generator):
  - Second sample is a repeat -> done=1, pass=0, period=1.
- rst mid-measurement: immediate return to IDLE with the reset values above; no partial result is retained.
- Bitmap: 2^N flops with single-bit set per cycle and bulk clear on start. Read is combinational on d.

Optional Feature:
NLPRG_PERIOD_CHECKER_DIAG_EN
- Defined: adds outputs rep_val (N bits) and rep_idx (N+1 bits).
  - On the terminating sample, rep_val<=d and rep_idx<=period (index of the repeated sample, 0-based count of prior distinct values).
  - Both reset to 0 and are cleared on accepted start.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Full cycle, N=7: start, then en=1 every cycle with d = 0,1,...,127,0 -> after the 129th sample edge, done=1, pass=1, period=128, first=0; busy=0.
- Early return to first: d = 5,9,5 -> done=1, pass=0, period=2, first=5; DIAG: rep_val=5, rep_idx=2.
- Lock-up tail: d = 3,4,5,4 -> done=1, pass=0, period=3; DIAG: rep_val=4, rep_idx=3.
- Stall and start-while-busy:
  - Stimulus: d = 10,11,12,10 with en low for 3 cycles between each sample, and start pulsed mid-run.
  - Required: start ignored; done=1 only after the 4th en sample; period=3; pass=0.
- Reset mid-run: assert rst after 50 samples of a counting stream -> busy=0, done=0, period=0 on the same cycle (async).
  - Then start plus a full 129-sample stream -> pass=1, period=128.
- Stuck generator: d held at 0 with en=1 -> done=1 two edges after CAPTURE entry, period=1, pass=0.
  - Then start again from DONE -> busy=1, done=0, bitmap cleared.
